// File: rtl/dmem_responder.sv
// dmem_responder
//   Responder for the processor data-memory port. Byte-addressed big-endian
//   store with a fixed access latency and a valid/ready request handshake, so
//   the processor's hold/kill logic can be exercised against a slow memory.
//
// Parameters
//   SIZE     storage size in bytes (power of two); addresses wrap modulo SIZE
//   LATENCY  cycles from the accepting edge to respValid (1..15)
//
// Ports
//   clk        rising-edge clock
//   memRst     asynchronous active-high reset (storage contents are kept)
//   reqValid   request present this cycle
//   reqReady   responder can accept a request this cycle
//   addr       byte address
//   wData      store data, right-justified
//   writeEn    1 = store, 0 = load
//   dsize      00 byte, 01 half, 1x word
//   respValid  one-cycle pulse when the access completes
//   rData      load data, zero-extended; 0 for stores and errors
//   respErr    misaligned access flag, valid with respValid
module dmem_responder #(
  parameter int unsigned SIZE    = 16384,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        memRst,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [31:0] addr,
  input  logic [31:0] wData,
  input  logic        writeEn,
  input  logic [1:0]  dsize,
  output logic        respValid,
  output logic [31:0] rData,
  output logic        respErr
);

  localparam int unsigned AW = $clog2(SIZE);
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] LAST_COUNT = CW'(LATENCY - 1);
  localparam bit SINGLE_CYCLE = (LATENCY == 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } stateT;

  // Request as captured at the accepting edge
  typedef struct packed {
    logic [AW-1:0] idx;
    logic [31:0]   data;
    logic          wr;
    logic [1:0]    size;
    logic          misaligned;
  } reqT;

  stateT         state;
  logic [CW-1:0] count;
  reqT           reqQ;

  logic [7:0] mem [SIZE];

  logic            accept;
  logic            misalignedIn;
  logic            commit;
  logic [3:0]      laneEn;
  logic [3:0][7:0] laneByte;
  logic [7:0]      rdByte0;
  logic [7:0]      rdByte1;
  logic [7:0]      rdByte2;
  logic [7:0]      rdByte3;
  logic [31:0]     loadData;
  logic [31:0]     respData;
  logic            addrUnused;

  // Address bits above the storage size are ignored (modulo-SIZE wrap)
  assign addrUnused = ^addr[31:AW];

  assign accept = reqValid & reqReady;

  // Half needs an even address, word needs addr[1:0] == 0
  always_comb begin
    misalignedIn = 1'b0;
    case (dsize)
      2'b00:   misalignedIn = 1'b0;
      2'b01:   misalignedIn = addr[0];
      default: misalignedIn = (addr[1:0] != 2'b00);
    endcase
  end

  // Store lane map: lane i is written to mem[idx + i], most significant byte first
  always_comb begin
    laneEn   = 4'b0000;
    laneByte = '0;
    case (reqQ.size)
      2'b00: begin
        laneEn      = 4'b0001;
        laneByte[0] = reqQ.data[7:0];
      end
      2'b01: begin
        laneEn      = 4'b0011;
        laneByte[0] = reqQ.data[15:8];
        laneByte[1] = reqQ.data[7:0];
      end
      default: begin
        laneEn      = 4'b1111;
        laneByte[0] = reqQ.data[31:24];
        laneByte[1] = reqQ.data[23:16];
        laneByte[2] = reqQ.data[15:8];
        laneByte[3] = reqQ.data[7:0];
      end
    endcase
  end

  // Stores land on the same edge that raises respValid; errors never write
  assign commit = (state == RESP) & reqQ.wr & ~reqQ.misaligned;

  // Storage has no reset so contents survive memRst
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (commit && laneEn[i]) begin
        mem[reqQ.idx + AW'(i)] <= laneByte[i];
      end
    end
  end

  // Aligned accesses never straddle the wrap, so the lane offsets can wrap freely
  assign rdByte0 = mem[reqQ.idx];
  assign rdByte1 = mem[reqQ.idx + AW'(1)];
  assign rdByte2 = mem[reqQ.idx + AW'(2)];
  assign rdByte3 = mem[reqQ.idx + AW'(3)];

  always_comb begin
    loadData = 32'h0;
    case (reqQ.size)
      2'b00:   loadData = {24'h0, rdByte0};
      2'b01:   loadData = {16'h0, rdByte0, rdByte1};
      default: loadData = {rdByte0, rdByte1, rdByte2, rdByte3};
    endcase
  end

  assign respData = (reqQ.wr || reqQ.misaligned) ? 32'h0 : loadData;

  // Control FSM with registered handshake and response outputs
  always_ff @(posedge clk or posedge memRst) begin
    if (memRst) begin
      state     <= IDLE;
      count     <= '0;
      reqReady  <= 1'b1;
      respValid <= 1'b0;
      rData     <= 32'h0;
      respErr   <= 1'b0;
      reqQ      <= '0;
    end else begin
      // Response fields only live for the single respValid cycle
      respValid <= 1'b0;
      rData     <= 32'h0;
      respErr   <= 1'b0;

      case (state)
        IDLE: begin
          reqReady <= 1'b1;
        end
        BUSY: begin
          if (count == LAST_COUNT) begin
            state    <= RESP;
            reqReady <= 1'b1;
            count    <= '0;
          end else begin
            count <= count + CW'(1);
          end
        end
        RESP: begin
          respValid <= 1'b1;
          rData     <= respData;
          respErr   <= reqQ.misaligned;
          state     <= IDLE;
          reqReady  <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          reqReady <= 1'b1;
          count    <= '0;
        end
      endcase

      // Acceptance is only possible in IDLE or RESP and overrides the return to IDLE
      if (accept) begin
        reqQ.idx        <= addr[AW-1:0];
        reqQ.data       <= wData;
        reqQ.wr         <= writeEn;
        reqQ.size       <= dsize;
        reqQ.misaligned <= misalignedIn;
        state           <= SINGLE_CYCLE ? RESP : BUSY;
        reqReady        <= SINGLE_CYCLE;
        count           <= CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder: the driver pushes expected
// responses from a byte-array reference model, a negedge monitor pops/compares.
module tb_dmem_responder;

  localparam int unsigned SIZE   = 16384;
  localparam int unsigned LAT    = 2;
  localparam time         PERIOD = 10;

  logic        clk;
  logic        memRst;
  logic        reqValid;
  logic        reqReady;
  logic [31:0] addr;
  logic [31:0] wData;
  logic        writeEn;
  logic [1:0]  dsize;
  logic        respValid;
  logic [31:0] rData;
  logic        respErr;

  dmem_responder #(.SIZE(SIZE), .LATENCY(LAT)) dut (
    .clk      (clk),
    .memRst   (memRst),
    .reqValid (reqValid),
    .reqReady (reqReady),
    .addr     (addr),
    .wData    (wData),
    .writeEn  (writeEn),
    .dsize    (dsize),
    .respValid(respValid),
    .rData    (rData),
    .respErr  (respErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    time         due;
  } expT;

  expT        expQ[$];
  expT        monE;
  logic [7:0] refMem [SIZE];
  int         vectors     = 0;
  int         miscompares = 0;
  bit         monOn       = 0;
  bit         chain       = 0;
  bit         lastValid   = 0;
  time        lastAccept  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference: byte array, big-endian, index = addr mod SIZE
  task automatic refAccess(input logic [31:0] a, input logic [31:0] d, input logic we,
                           input logic [1:0] sz, output logic [31:0] rd, output logic err);
    int unsigned idx;
    int unsigned nb;
    idx = a % SIZE;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err = ((nb == 2) && (a % 2 != 0)) || ((nb == 4) && (a % 4 != 0));
    rd  = 32'h0;
    if (!err) begin
      for (int i = 0; i < int'(nb); i++) begin
        if (we) refMem[idx + i] = 8'(d >> (8 * (int'(nb) - 1 - i)));
        else    rd = (rd << 8) | 32'(refMem[idx + i]);
      end
    end
  endtask

  // Monitor: compare each response against the scoreboard head
  always @(negedge clk) begin
    if (monOn) begin
      if (respValid) begin
        if (expQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious_resp: got respValid=1 want no response (rData=0x%0h) at %0t",
                   rData, $time);
        end else begin
          monE = expQ.pop_front();
          check("rData", 64'(rData), 64'(monE.data));
          check("respErr", 64'(respErr), 64'(monE.err));
          check("resp_time", 64'($time), 64'(monE.due));
        end
      end else begin
        check("idle_rData", 64'(rData), 64'h0);
        check("idle_respErr", 64'(respErr), 64'h0);
      end
    end
  end

  // Present one request, hold until accepted, then scramble the bus
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic we,
                       input logic [1:0] sz, input bit abort);
    bit          rdy;
    bit          ok;
    time         tAcc;
    logic [31:0] rd;
    logic        err;
    addr     = a;
    wData    = d;
    writeEn  = we;
    dsize    = sz;
    reqValid = 1'b1;
    ok       = 0;
    rdy      = 0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      rdy = reqReady;
      @(posedge clk);
      if (rdy) begin
        ok = 1;
        break;
      end
    end
    tAcc = $time;
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: got no accept want accept within 64 cycles addr=0x%0h", a);
    end else begin
      if (chain && lastValid) check("b2b_accept_gap", 64'(tAcc - lastAccept), 64'(LAT * PERIOD));
      lastAccept = tAcc;
      lastValid  = !abort;
      if (!abort) begin
        refAccess(a, d, we, sz, rd, err);
        expQ.push_back('{rd, err, tAcc + LAT * PERIOD + PERIOD / 2});
      end
    end
    chain = 1;
    #1;
    reqValid = 1'b0;
    addr     = $urandom;
    wData    = $urandom;
    writeEn  = 1'($urandom);
    dsize    = 2'($urandom);
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
    if (n > 0) chain = 0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && expQ.size() > 0; n++) @(posedge clk);
    #1;
    if (expQ.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d pending responses want 0", expQ.size());
      expQ.delete();
    end
    chain = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    memRst   = 1'b1;
    reqValid = 1'b0;
    addr     = 32'h0;
    wData    = 32'h0;
    writeEn  = 1'b0;
    dsize    = 2'b00;

    repeat (2) @(posedge clk);
    #1;
    check("reset_reqReady", 64'(reqReady), 64'h1);
    check("reset_respValid", 64'(respValid), 64'h0);
    check("reset_rData", 64'(rData), 64'h0);
    check("reset_respErr", 64'(respErr), 64'h0);
    memRst = 1'b0;
    monOn  = 1;

    // Fill the 256-byte window so every later load has known contents
    for (int i = 0; i < 64; i++) issue(32'(i * 4), $urandom, 1'b1, 2'd2, 0);

    // Word store/load and its big-endian byte placement
    issue(32'h10, 32'hDEADBEEF, 1'b1, 2'd2, 0);
    issue(32'h10, 32'h0, 1'b0, 2'd2, 0);
    issue(32'h10, 32'h0, 1'b0, 2'd0, 0);
    issue(32'h13, 32'h0, 1'b0, 2'd0, 0);
    // Byte merge into a word
    issue(32'h20, 32'h11223344, 1'b1, 2'd2, 0);
    issue(32'h21, 32'h000000AB, 1'b1, 2'd0, 0);
    issue(32'h20, 32'h0, 1'b0, 2'd2, 0);
    issue(32'h21, 32'h0, 1'b0, 2'd0, 0);
    issue(32'h20, 32'h0, 1'b0, 2'd1, 0);
    // Misaligned accesses: error, no write
    issue(32'h23, 32'h0, 1'b0, 2'd1, 0);
    issue(32'h22, 32'hFFFFFFFF, 1'b1, 2'd2, 0);
    issue(32'h21, 32'hFFFFFFFF, 1'b1, 2'd3, 0);
    issue(32'h20, 32'h0, 1'b0, 2'd2, 0);
    // Wrap at SIZE
    issue(32'h00004000, 32'hCAFEF00D, 1'b1, 2'd2, 0);
    issue(32'h0, 32'h0, 1'b0, 2'd2, 0);
    // Held reqValid: four back-to-back loads
    gap(2);
    for (int i = 0; i < 4; i++) issue(32'(32'h30 + i * 4), 32'h0, 1'b0, 2'd2, 0);

    // Reset while a store is in flight: no response, no write
    drain();
    gap(2);
    issue(32'h40, 32'h55AA55AA, 1'b1, 2'd2, 1);
    memRst = 1'b1;
    #1;
    check("midrst_reqReady", 64'(reqReady), 64'h1);
    check("midrst_respValid", 64'(respValid), 64'h0);
    repeat (LAT) @(posedge clk);
    #3;
    check("midrst_hold_reqReady", 64'(reqReady), 64'h1);
    memRst = 1'b0;
    @(negedge clk);
    check("postrst_reqReady", 64'(reqReady), 64'h1);
    @(posedge clk);
    #1;
    chain     = 0;
    lastValid = 0;
    issue(32'h40, 32'h0, 1'b0, 2'd2, 0);

    // Random traffic inside the window, upper address bits scrambled for wrap
    for (int i = 0; i < 300; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom & 32'hFFFF_C0FF;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        else if (sz[1]) a[1:0] = 2'b00;
      end
      issue(a, $urandom, 1'($urandom_range(0, 1)), sz, 0);
      if ($urandom_range(0, 1) == 1) gap($urandom_range(1, 3));
    end

    drain();
    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
